// File: rtl/decode_stage.sv
// Pipelined MIPS decode stage: decodes the IF/ID instruction and registers the
// control word, operand selects and extended immediate into the ID/EX latch.
module decode_stage #(
  parameter int PC_W         = 32,
  parameter bit LOAD_USE_CHK = 1'b1,
  parameter bit HALT_STICKY  = 1'b1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [PC_W-1:0] id_pc_plus4,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            ex_dren_cur,
  input  logic [4:0]      ex_wsel_cur,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [3:0]      ex_aluop,
  output logic            ex_alusrc,
  output logic            ex_dren,
  output logic            ex_dwen,
  output logic            ex_regwr,
  output logic            ex_memtoreg,
  output logic            ex_jump,
  output logic            ex_jal,
  output logic            ex_jr,
  output logic            ex_beq,
  output logic            ex_bne,
  output logic            ex_lui,
  output logic            ex_shift,
  output logic [4:0]      ex_wsel,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [31:0]     ex_imm32,
  output logic [25:0]     ex_jaddr,
  output logic [PC_W-1:0] ex_pc_plus4,
  output logic            ex_illegal,
  output logic            halt
);

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'hA,
    ALU_SLTU = 4'hB
  } aluop_t;

  typedef struct packed {
    logic            valid;
    aluop_t          aluop;
    logic            alusrc;
    logic            dren;
    logic            dwen;
    logic            regwr;
    logic            memtoreg;
    logic            jump;
    logic            jal;
    logic            jr;
    logic            beq;
    logic            bne;
    logic            lui;
    logic            shift;
    logic            illegal;
    logic            halt;
    logic [4:0]      wsel;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [31:0]     imm32;
    logic [25:0]     jaddr;
    logic [PC_W-1:0] pc;
  } word_t;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic        w_rt_src;
  logic        w_illegal;
  logic        w_bubble;
  word_t       w_dec;
  word_t       r_word;
  logic        r_halt;

  assign w_op    = id_instr[31:26];
  assign w_rs    = id_instr[25:21];
  assign w_rt    = id_instr[20:16];
  assign w_rd    = id_instr[15:11];
  assign w_shamt = id_instr[10:6];
  assign w_fn    = id_instr[5:0];
  assign w_imm   = id_instr[15:0];
  assign w_sext  = {{16{w_imm[15]}}, w_imm};
  assign w_zext  = {16'h0000, w_imm};

  always_comb begin
    w_dec       = '0;
    w_rt_src    = 1'b0;
    w_illegal   = 1'b0;
    w_dec.valid = 1'b1;
    w_dec.rs    = w_rs;
    w_dec.rt    = w_rt;
    w_dec.wsel  = w_rt;
    w_dec.imm32 = w_sext;
    w_dec.jaddr = id_instr[25:0];
    w_dec.pc    = id_pc_plus4;
    case (w_op)
      6'h00: begin
        w_dec.wsel = w_rd;
        w_rt_src   = 1'b1;
        case (w_fn)
          6'h20, 6'h21: begin w_dec.aluop = ALU_ADD;  w_dec.regwr = 1'b1; end
          6'h22, 6'h23: begin w_dec.aluop = ALU_SUB;  w_dec.regwr = 1'b1; end
          6'h24:        begin w_dec.aluop = ALU_AND;  w_dec.regwr = 1'b1; end
          6'h25:        begin w_dec.aluop = ALU_OR;   w_dec.regwr = 1'b1; end
          6'h26:        begin w_dec.aluop = ALU_XOR;  w_dec.regwr = 1'b1; end
          6'h27:        begin w_dec.aluop = ALU_NOR;  w_dec.regwr = 1'b1; end
          6'h2A:        begin w_dec.aluop = ALU_SLT;  w_dec.regwr = 1'b1; end
          6'h2B:        begin w_dec.aluop = ALU_SLTU; w_dec.regwr = 1'b1; end
          6'h00, 6'h02: begin
            w_dec.aluop = (w_fn == 6'h00) ? ALU_SLL : ALU_SRL;
            w_dec.shift = 1'b1;
            w_dec.regwr = 1'b1;
            w_dec.imm32 = {27'd0, w_shamt};
          end
          6'h08:   w_dec.jr = 1'b1;
          default: w_illegal = 1'b1;
        endcase
      end
      6'h02: w_dec.jump = 1'b1;
      6'h03: begin w_dec.jal = 1'b1; w_dec.regwr = 1'b1; w_dec.wsel = 5'd31; end
      6'h04: begin w_dec.aluop = ALU_SUB; w_dec.beq = 1'b1; w_rt_src = 1'b1; end
      6'h05: begin w_dec.aluop = ALU_SUB; w_dec.bne = 1'b1; w_rt_src = 1'b1; end
      6'h08, 6'h09: begin w_dec.aluop = ALU_ADD;  w_dec.alusrc = 1'b1; w_dec.regwr = 1'b1; end
      6'h0A:        begin w_dec.aluop = ALU_SLT;  w_dec.alusrc = 1'b1; w_dec.regwr = 1'b1; end
      6'h0B:        begin w_dec.aluop = ALU_SLTU; w_dec.alusrc = 1'b1; w_dec.regwr = 1'b1; end
      6'h0C, 6'h0D, 6'h0E: begin
        w_dec.aluop  = (w_op == 6'h0C) ? ALU_AND : ((w_op == 6'h0D) ? ALU_OR : ALU_XOR);
        w_dec.alusrc = 1'b1;
        w_dec.regwr  = 1'b1;
        w_dec.imm32  = w_zext;
      end
      6'h0F: begin w_dec.lui = 1'b1; w_dec.regwr = 1'b1; w_dec.imm32 = {w_imm, 16'h0000}; end
      6'h23: begin
        w_dec.aluop    = ALU_ADD;
        w_dec.alusrc   = 1'b1;
        w_dec.dren     = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.regwr    = 1'b1;
      end
      6'h2B: begin w_dec.aluop = ALU_ADD; w_dec.alusrc = 1'b1; w_dec.dwen = 1'b1; w_rt_src = 1'b1; end
      6'h3F: w_dec.halt = 1'b1;
      default: w_illegal = 1'b1;
    endcase
    if (w_dec.wsel == 5'd0) w_dec.regwr = 1'b0;
    // Illegal words travel as a live but inert bubble so EX can trap on them.
    if (w_illegal) begin
      w_dec         = '0;
      w_dec.valid   = 1'b1;
      w_dec.illegal = 1'b1;
    end
  end

  assign hazard_stall = LOAD_USE_CHK & id_valid & ex_valid & ex_dren_cur & (ex_wsel_cur != 5'd0) &
                        ((ex_wsel_cur == w_rs) | (w_rt_src & (ex_wsel_cur == w_rt)));

  assign w_bubble = flush | hazard_stall | ~id_valid | (HALT_STICKY & r_halt);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_word <= '0;
      r_halt <= 1'b0;
    end else if (!stall_in) begin
      r_word <= w_bubble ? '0 : w_dec;
      r_halt <= r_halt | (~w_bubble & w_dec.halt);
    end
  end

  assign halt         = HALT_STICKY ? r_halt : r_word.halt;
  assign ex_valid     = r_word.valid;
  assign ex_aluop     = r_word.aluop;
  assign ex_alusrc    = r_word.alusrc;
  assign ex_dren      = r_word.dren;
  assign ex_dwen      = r_word.dwen;
  assign ex_regwr     = r_word.regwr;
  assign ex_memtoreg  = r_word.memtoreg;
  assign ex_jump      = r_word.jump;
  assign ex_jal       = r_word.jal;
  assign ex_jr        = r_word.jr;
  assign ex_beq       = r_word.beq;
  assign ex_bne       = r_word.bne;
  assign ex_lui       = r_word.lui;
  assign ex_shift     = r_word.shift;
  assign ex_wsel      = r_word.wsel;
  assign ex_rs        = r_word.rs;
  assign ex_rt        = r_word.rt;
  assign ex_imm32     = r_word.imm32;
  assign ex_jaddr     = r_word.jaddr;
  assign ex_pc_plus4  = r_word.pc;
  assign ex_illegal   = r_word.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction vectors plus
// hand-written hazard, stall/flush, halt and reset sequences.
module tb_decode_stage;

  localparam logic [13:0] ALUSRC = 14'h0001, DREN = 14'h0002, DWEN = 14'h0004, REGWR = 14'h0008;
  localparam logic [13:0] MEM2R  = 14'h0010, JUMP = 14'h0020, JAL  = 14'h0040, JR    = 14'h0080;
  localparam logic [13:0] BEQ    = 14'h0100, BNE  = 14'h0200, LUI  = 14'h0400, SHIFT = 14'h0800;
  localparam logic [13:0] ILL    = 14'h1000, VLD  = 14'h2000;

  localparam logic [3:0] A_SLL = 4'h0, A_SRL = 4'h1, A_ADD = 4'h2, A_SUB = 4'h3, A_AND = 4'h4;
  localparam logic [3:0] A_OR = 4'h5, A_XOR = 4'h6, A_NOR = 4'h7, A_SLT = 4'hA, A_SLTU = 4'hB;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [13:0] ctrl;
    logic        chkAlu;
    logic [3:0]  alu;
    logic        chkImm;
    logic [31:0] imm;
    logic        chkFld;
    logic [4:0]  wsel;
  } vec_t;

  vec_t vecs[$];

  logic        CLK, nRST, idValid, stallIn, flushIn, exDrenCur;
  logic [31:0] idInstr, idPc;
  logic [4:0]  exWselCur;

  logic        hazardStall, exValid, exAlusrc, exDren, exDwen, exRegwr, exMemtoreg;
  logic        exJump, exJal, exJr, exBeq, exBne, exLui, exShift, exIllegal, haltOut;
  logic [3:0]  exAluop;
  logic [4:0]  exWsel, exRs, exRt;
  logic [31:0] exImm32, exPc;
  logic [25:0] exJaddr;

  logic        bHazard, bValid, bAlusrc, bDren, bDwen, bRegwr, bMemtoreg;
  logic        bJump, bJal, bJr, bBeq, bBne, bLui, bShift, bIllegal, bHalt;
  logic [3:0]  bAluop;
  logic [4:0]  bWsel, bRs, bRt;
  logic [31:0] bImm32, bPc;
  logic [25:0] bJaddr;

  logic [13:0] actCtrl, bCtrl;
  int checks = 0;
  int errors = 0;

  assign actCtrl = {exValid, exIllegal, exShift, exLui, exBne, exBeq, exJr, exJal, exJump,
                    exMemtoreg, exRegwr, exDwen, exDren, exAlusrc};
  assign bCtrl   = {bValid, bIllegal, bShift, bLui, bBne, bBeq, bJr, bJal, bJump,
                    bMemtoreg, bRegwr, bDwen, bDren, bAlusrc};

  decode_stage #(.PC_W(32), .LOAD_USE_CHK(1'b1), .HALT_STICKY(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .id_valid(idValid), .id_instr(idInstr), .id_pc_plus4(idPc),
    .stall_in(stallIn), .flush(flushIn), .ex_dren_cur(exDrenCur), .ex_wsel_cur(exWselCur),
    .hazard_stall(hazardStall), .ex_valid(exValid), .ex_aluop(exAluop), .ex_alusrc(exAlusrc),
    .ex_dren(exDren), .ex_dwen(exDwen), .ex_regwr(exRegwr), .ex_memtoreg(exMemtoreg),
    .ex_jump(exJump), .ex_jal(exJal), .ex_jr(exJr), .ex_beq(exBeq), .ex_bne(exBne),
    .ex_lui(exLui), .ex_shift(exShift), .ex_wsel(exWsel), .ex_rs(exRs), .ex_rt(exRt),
    .ex_imm32(exImm32), .ex_jaddr(exJaddr), .ex_pc_plus4(exPc), .ex_illegal(exIllegal),
    .halt(haltOut)
  );

  decode_stage #(.PC_W(32), .LOAD_USE_CHK(1'b0), .HALT_STICKY(1'b0)) dutB (
    .CLK(CLK), .nRST(nRST), .id_valid(idValid), .id_instr(idInstr), .id_pc_plus4(idPc),
    .stall_in(stallIn), .flush(flushIn), .ex_dren_cur(exDrenCur), .ex_wsel_cur(exWselCur),
    .hazard_stall(bHazard), .ex_valid(bValid), .ex_aluop(bAluop), .ex_alusrc(bAlusrc),
    .ex_dren(bDren), .ex_dwen(bDwen), .ex_regwr(bRegwr), .ex_memtoreg(bMemtoreg),
    .ex_jump(bJump), .ex_jal(bJal), .ex_jr(bJr), .ex_beq(bBeq), .ex_bne(bBne),
    .ex_lui(bLui), .ex_shift(bShift), .ex_wsel(bWsel), .ex_rs(bRs), .ex_rt(bRt),
    .ex_imm32(bImm32), .ex_jaddr(bJaddr), .ex_pc_plus4(bPc), .ex_illegal(bIllegal),
    .halt(bHalt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic addVec(input logic [31:0] instr, input logic valid, input logic [13:0] ctrl,
                        input logic chkAlu, input logic [3:0] alu, input logic chkImm,
                        input logic [31:0] imm, input logic chkFld, input logic [4:0] wsel);
    vec_t v;
    v.instr = instr; v.valid = valid; v.ctrl = ctrl; v.chkAlu = chkAlu; v.alu = alu;
    v.chkImm = chkImm; v.imm = imm; v.chkFld = chkFld; v.wsel = wsel;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic st,
                               input logic fl, input logic dr, input logic [4:0] ws);
    idInstr   = instr;
    idValid   = valid;
    stallIn   = st;
    flushIn   = fl;
    exDrenCur = dr;
    exWselCur = ws;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " ctrl"}, 32'(actCtrl), 32'h0);
    checkOutput({tag, " aluop"}, 32'(exAluop), 32'h0);
    checkOutput({tag, " regs"}, 32'({exWsel, exRs, exRt}), 32'h0);
    checkOutput({tag, " imm32"}, exImm32, 32'h0);
    checkOutput({tag, " jaddr"}, 32'(exJaddr), 32'h0);
    checkOutput({tag, " pc"}, exPc, 32'h0);
    checkOutput({tag, " halt"}, 32'(haltOut), 32'h0);
  endtask

  initial begin
    addVec(32'h20010005, 1, VLD|ALUSRC|REGWR,            1, A_ADD,  1, 32'h00000005, 1, 5'd1);
    addVec(32'h3421FFFF, 1, VLD|ALUSRC|REGWR,            1, A_OR,   1, 32'h0000FFFF, 1, 5'd1);
    addVec(32'h2021FFFF, 1, VLD|ALUSRC|REGWR,            1, A_ADD,  1, 32'hFFFFFFFF, 1, 5'd1);
    addVec(32'h3C011234, 1, VLD|LUI|REGWR,               0, A_SLL,  1, 32'h12340000, 1, 5'd1);
    addVec(32'h00411820, 1, VLD|REGWR,                   1, A_ADD,  0, 32'h0,        1, 5'd3);
    addVec(32'h00430821, 1, VLD|REGWR,                   1, A_ADD,  0, 32'h0,        1, 5'd1);
    addVec(32'h00011100, 1, VLD|REGWR|SHIFT,             1, A_SLL,  1, 32'h00000004, 1, 5'd2);
    addVec(32'h000117C2, 1, VLD|REGWR|SHIFT,             1, A_SRL,  1, 32'h0000001F, 1, 5'd2);
    addVec(32'h00A62022, 1, VLD|REGWR,                   1, A_SUB,  0, 32'h0,        1, 5'd4);
    addVec(32'h0022382A, 1, VLD|REGWR,                   1, A_SLT,  0, 32'h0,        1, 5'd7);
    addVec(32'h00430827, 1, VLD|REGWR,                   1, A_NOR,  0, 32'h0,        1, 5'd1);
    addVec(32'h2823FFFE, 1, VLD|ALUSRC|REGWR,            1, A_SLT,  1, 32'hFFFFFFFE, 1, 5'd3);
    addVec(32'h2C230001, 1, VLD|ALUSRC|REGWR,            1, A_SLTU, 1, 32'h00000001, 1, 5'd3);
    addVec(32'h30258000, 1, VLD|ALUSRC|REGWR,            1, A_AND,  1, 32'h00008000, 1, 5'd5);
    addVec(32'h38258001, 1, VLD|ALUSRC|REGWR,            1, A_XOR,  1, 32'h00008001, 1, 5'd5);
    addVec(32'h8C220004, 1, VLD|ALUSRC|DREN|MEM2R|REGWR, 1, A_ADD,  1, 32'h00000004, 1, 5'd2);
    addVec(32'hAC22FFFC, 1, VLD|ALUSRC|DWEN,             1, A_ADD,  1, 32'hFFFFFFFC, 1, 5'd2);
    addVec(32'h1022FFFF, 1, VLD|BEQ,                     1, A_SUB,  1, 32'hFFFFFFFF, 1, 5'd2);
    addVec(32'h1422FFFF, 1, VLD|BNE,                     1, A_SUB,  1, 32'hFFFFFFFF, 1, 5'd2);
    addVec(32'h0C000010, 1, VLD|JAL|REGWR,               0, A_SLL,  0, 32'h0,        1, 5'd31);
    addVec(32'h08000040, 1, VLD|JUMP,                    0, A_SLL,  0, 32'h0,        1, 5'd0);
    addVec(32'h00000008, 1, VLD|JR,                      0, A_SLL,  0, 32'h0,        1, 5'd0);
    addVec(32'h20200007, 1, VLD|ALUSRC,                  1, A_ADD,  1, 32'h00000007, 1, 5'd0);
    addVec(32'h7C000000, 1, VLD|ILL,                     0, A_SLL,  0, 32'h0,        0, 5'd0);
    addVec(32'h0000003F, 1, VLD|ILL,                     0, A_SLL,  0, 32'h0,        0, 5'd0);
    addVec(32'h20010005, 0, 14'h0,                       0, A_SLL,  0, 32'h0,        0, 5'd0);

    nRST = 1'b0;
    idPc = 32'h0000_0FFC;
    applyStimulus(32'h20010005, 1, 0, 0, 0, 5'd0);
    tick;
    checkCleared("reset");
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      idPc = 32'h1000 + 32'(i * 4);
      applyStimulus(vecs[i].instr, vecs[i].valid, 0, 0, 0, 5'd0);
      tick;
      checkOutput($sformatf("v%0d ctrl", i), 32'(actCtrl), 32'(vecs[i].ctrl));
      if (vecs[i].chkAlu) checkOutput($sformatf("v%0d aluop", i), 32'(exAluop), 32'(vecs[i].alu));
      if (vecs[i].chkImm) checkOutput($sformatf("v%0d imm32", i), exImm32, vecs[i].imm);
      if (vecs[i].chkFld) begin
        checkOutput($sformatf("v%0d wsel", i), 32'(exWsel), 32'(vecs[i].wsel));
        checkOutput($sformatf("v%0d rs/rt", i), 32'({exRs, exRt}), 32'(vecs[i].instr[25:16]));
        checkOutput($sformatf("v%0d jaddr", i), 32'(exJaddr), 32'(vecs[i].instr[25:0]));
        checkOutput($sformatf("v%0d pc", i), exPc, idPc);
      end
    end

    // Load-use interlock with a lw to $2 sitting in EX.
    applyStimulus(32'h8C220004, 1, 0, 0, 0, 5'd0);
    tick;
    checkOutput("lw ctrl", 32'(actCtrl), 32'(VLD|ALUSRC|DREN|MEM2R|REGWR));
    applyStimulus(32'h00411820, 1, 0, 0, 1, 5'd0);
    #1 checkOutput("haz wsel0", 32'(hazardStall), 32'h0);
    applyStimulus(32'h00411820, 1, 0, 0, 1, 5'd2);
    #1 checkOutput("haz rs", 32'(hazardStall), 32'h1);
    checkOutput("haz disabled", 32'(bHazard), 32'h0);
    applyStimulus(32'h00221820, 1, 0, 0, 1, 5'd2);
    #1 checkOutput("haz rt rtype", 32'(hazardStall), 32'h1);
    applyStimulus(32'h20220005, 1, 0, 0, 1, 5'd2);
    #1 checkOutput("haz rt dest", 32'(hazardStall), 32'h0);
    applyStimulus(32'hAC220000, 1, 0, 0, 1, 5'd2);
    #1 checkOutput("haz rt sw", 32'(hazardStall), 32'h1);
    applyStimulus(32'h00411820, 1, 0, 0, 1, 5'd2);
    tick;
    checkOutput("haz bubble", 32'(actCtrl), 32'h0);
    checkOutput("haz disabled load", 32'(bCtrl), 32'(VLD|REGWR));
    checkOutput("haz after bubble", 32'(hazardStall), 32'h0);

    // Stall holds the latched sw, even with a flush presented alongside.
    applyStimulus(32'hAC22FFFC, 1, 0, 0, 0, 5'd0);
    tick;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h20010005, 1, 1, (k == 1), 0, 5'd0);
      tick;
      checkOutput($sformatf("stall%0d ctrl", k), 32'(actCtrl), 32'(VLD|ALUSRC|DWEN));
      checkOutput($sformatf("stall%0d imm32", k), exImm32, 32'hFFFFFFFC);
    end
    applyStimulus(32'h20010005, 1, 0, 1, 0, 5'd0);
    tick;
    checkOutput("flush ctrl", 32'(actCtrl), 32'h0);

    // Halt: sticky on the main instance, one-cycle on the second.
    applyStimulus(32'hFFFFFFFF, 1, 0, 0, 0, 5'd0);
    tick;
    checkOutput("halt rise", 32'(haltOut), 32'h1);
    checkOutput("halt rise pulse", 32'(bHalt), 32'h1);
    checkOutput("halt word", 32'(actCtrl), 32'(VLD));
    applyStimulus(32'h20010005, 1, 0, 0, 0, 5'd0);
    tick;
    checkOutput("halt sticky", 32'(haltOut), 32'h1);
    checkOutput("halt squash", 32'(actCtrl), 32'h0);
    checkOutput("halt pulse drop", 32'(bHalt), 32'h0);
    checkOutput("halt pulse load", 32'(bCtrl), 32'(VLD|ALUSRC|REGWR));
    tick;
    checkOutput("halt sticky2", 32'(haltOut), 32'h1);
    nRST = 1'b0;
    tick;
    checkCleared("halt reset");
    nRST = 1'b1;

    applyStimulus(32'hFFFFFFFF, 1, 0, 1, 0, 5'd0);
    tick;
    checkOutput("flushed halt", 32'(haltOut), 32'h0);
    checkOutput("flushed halt pulse", 32'(bHalt), 32'h0);
    applyStimulus(32'h20010005, 1, 0, 0, 0, 5'd0);
    tick;
    checkOutput("post flush load", 32'(actCtrl), 32'(VLD|ALUSRC|REGWR));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
